// File: rtl/bsg_two_fifo_rr_sched.sv
// rtl/bsg_two_fifo_rr_sched.sv - round-robin drain of two-element FIFOs onto one ready/valid channel
// Grants one non-empty source per cycle, optionally holding it for up to burst_p transfers.
module bsg_two_fifo_rr_sched #(
    parameter int width_p   = 8,
    parameter int els_p     = 4,
    parameter int burst_p   = 1,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [lg_els_lp-1:0]       tag_o,
    input  logic                       ready_i,
    output logic [els_p-1:0]           grant_o
);

    localparam int cnt_w_lp = $clog2(burst_p + 1);
    localparam logic [cnt_w_lp-1:0]  burst_lp    = cnt_w_lp'(burst_p);
    localparam logic [lg_els_lp-1:0] last_rst_lp = lg_els_lp'(els_p - 1);

    logic [lg_els_lp-1:0] last_q, last_d;
    logic [cnt_w_lp-1:0]  cnt_q, cnt_d;

    logic                 hold;
    logic                 scan_found;
    logic [lg_els_lp-1:0] scan_idx;
    logic [lg_els_lp-1:0] grant_idx;
    logic [els_p-1:0]     grant_oh;
    logic [width_p-1:0]   grant_data;
    logic                 xfer;
    int                   k;

    // Scan starts just past the last served source so last_q is considered last.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        k          = 0;
        for (int off = 1; off <= els_p; off++) begin
            k = int'(last_q) + off;
            if (k >= els_p) begin
                k = k - els_p;
            end
            if (!scan_found && v_i[k]) begin
                scan_found = 1'b1;
                scan_idx   = lg_els_lp'(k);
            end
        end
    end

    always_comb begin
        hold       = (cnt_q < burst_lp) && v_i[last_q];
        grant_idx  = hold ? last_q : scan_idx;
        grant_oh   = '0;
        grant_data = '0;
        for (int i = 0; i < els_p; i++) begin
            if (grant_idx == lg_els_lp'(i)) begin
                grant_oh[i] = 1'b1;
                grant_data  = data_i[i*width_p +: width_p];
            end
        end
    end

    // Reset masks the channel so no FIFO dequeues while state is being cleared.
    always_comb begin
        v_o     = ~reset_i & (|v_i);
        xfer    = v_o & ready_i;
        grant_o = v_o ? grant_oh : '0;
        data_o  = v_o ? grant_data : '0;
        tag_o   = v_o ? grant_idx : '0;
        yumi_o  = xfer ? grant_oh : '0;
    end

    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (xfer) begin
            if (hold) begin
                cnt_d = (cnt_q < burst_lp) ? cnt_q + cnt_w_lp'(1) : burst_lp;
            end else begin
                cnt_d  = cnt_w_lp'(1);
                last_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= last_rst_lp;
            cnt_q  <= burst_lp;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($onehot0(yumi_o));
            assert ((yumi_o & ~v_i) == '0);
            assert (cnt_q <= burst_lp);
        end
    end
`endif

endmodule
